// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
//
// Purpose: common definitions for the UART receiver and transmitter.
//   DATA_BITS, OVERSAMPLE : default frame payload width and ticks per bit
//   CLK_FREQ_HZ, BAUD_RATE: system clock and line rate for the baud generator
//   BAUD_DIV              : clk cycles between rxClkEn strobes (27 at 50 MHz/115200)
//   rxState_t             : receiver FSM states
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int BAUD_RATE   = 115_200;
    localparam int BAUD_DIV    = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous single-bit input
//
// Purpose: bring an asynchronous level into the clk domain.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (both flops load RESET_VAL)
//   d    : asynchronous input
//   q    : synchronized output, two clk cycles behind d
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8N1 by default
//
// Purpose: deframes start/data/stop bits from rx, sampling each bit at its
// middle using rxClkEn ticks, and holds the last good byte for a consumer.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   rxClkEn  : single-cycle strobe at OVERSAMPLE x baud rate
//   rx       : asynchronous serial line, idle high
//   rxData   : last good received byte
//   rxValid  : rxData holds an unconsumed byte
//   rxAck    : consumer accepts rxData
//   frameErr : one-cycle pulse on a bad stop bit
//   overrun  : one-cycle pulse when a good frame is dropped
//   busy     : high whenever the FSM is not in IDLE
module uart_rx #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxClkEn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxAck,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rxState_t              state, nextState;
    logic [TW-1:0]         tickCnt, nextTick;
    logic [BW-1:0]         bitCnt, nextBit;
    logic [DATA_BITS-1:0]  shiftReg;
    logic                  rxS;
    logic                  shiftEn;
    logic                  stopTick;

    sync2 #(.RESET_VAL(1'b1)) rxSync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxS)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tickCnt <= '0;
            bitCnt  <= '0;
        end else begin
            state   <= nextState;
            tickCnt <= nextTick;
            bitCnt  <= nextBit;
        end
    end

    // Everything advances only on rxClkEn; between strobes the FSM is frozen.
    always_comb begin
        nextState = state;
        nextTick  = tickCnt;
        nextBit   = bitCnt;
        shiftEn   = 1'b0;
        stopTick  = 1'b0;
        if (rxClkEn) begin
            case (state)
                IDLE: begin
                    if (!rxS) begin
                        nextState = START;
                        nextTick  = '0;
                    end
                end
                START: begin
                    // Half a bit in: still low means a real start bit,
                    // otherwise it was a glitch and we quietly go back.
                    if (tickCnt == TICK_HALF) begin
                        nextTick  = '0;
                        nextBit   = '0;
                        nextState = rxS ? IDLE : DATA;
                    end else begin
                        nextTick = tickCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tickCnt == TICK_LAST) begin
                        nextTick = '0;
                        shiftEn  = 1'b1;
                        nextBit  = bitCnt + 1'b1;
                        if (bitCnt == BIT_LAST) begin
                            nextState = STOP;
                        end
                    end else begin
                        nextTick = tickCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tickCnt == TICK_LAST) begin
                        nextTick  = '0;
                        stopTick  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextTick = tickCnt + 1'b1;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // LSB arrives first, so new bits enter at the top and walk down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftReg <= '0;
        end else if (shiftEn) begin
            shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
        end
    end

    // An ack in the same cycle as a good stop frees the holding register,
    // so the new byte replaces the old one instead of being dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxData   <= '0;
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            frameErr <= 1'b0;
            overrun  <= 1'b0;
            if (rxAck) begin
                rxValid <= 1'b0;
            end
            if (stopTick) begin
                if (!rxS) begin
                    frameErr <= 1'b1;
                end else if (!rxValid || rxAck) begin
                    rxData  <= shiftReg;
                    rxValid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
